obi_mem_arbiter: RTL

Shares one single-port, 1-cycle-latency on-chip SRAM between the core's instruction-fetch and data OBI ports.
- Grants at most one requester per cycle.
- Issues the SRAM access in the grant cycle.
- Routes the response back exactly one cycle later.
- Sits inside bus, between the core interfaces and the unified RAM; accesses outside the RAM window are absorbed with an error pulse.

---
 rtl/obi_arb_pkg.sv | 25 ++
 rtl/rr_arb2.sv | 40 ++++
 rtl/obi_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/obi_arb_pkg.sv
// Shared types, constants and helpers for the OBI instruction/data memory arbiter.
package obi_arb_pkg;

    // Identifies which master a response (or the last grant) belongs to.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

    // True when a byte address falls inside the RAM window [base, base + 4*2^aw).
    // The subtraction wraps for addresses below base, which pushes them out of range.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input int unsigned aw);
        logic [32:0] off;
        logic [32:0] lim;
        off = {1'b0, addr - base};
        lim = 33'd1 << (aw + 32'd2);
        return off < lim;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: index 0 is the instruction port, index 1 the data port.
module rr_arb2
    import obi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt
);

    owner_e r_rr_last;
    owner_e w_rr_next;

    // Pick the winner; on a conflict the master that did not win last time goes first.
    always_comb begin
        gnt       = 2'b00;
        w_rr_next = r_rr_last;
        if (rstn) begin
            if (req == 2'b11) begin
                gnt = (r_rr_last == OWN_DATA) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
        if (adv) begin
            w_rr_next = gnt[1] ? OWN_DATA : OWN_INSTR;
        end
    end

    // Remember the most recent winner; starting at INSTR lets data win the first conflict.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_last <= OWN_INSTR;
        end else begin
            r_rr_last <= w_rr_next;
        end
    end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one single-port 1-cycle SRAM between the instruction and data OBI ports,
// absorbing out-of-window accesses with an error response and a bus_err pulse.
module obi_mem_arbiter
    import obi_arb_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              instr_req,
    input  logic [31:0]       instr_addr,
    output logic              instr_gnt,
    output logic              instr_rvalid,
    output logic [31:0]       instr_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_be,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              bus_err,
    output logic [31:0]       err_addr
);

    logic [1:0]  w_gnt;
    logic        w_any_gnt;
    logic        w_sel_data;
    logic        w_is_store;
    logic [31:0] w_addr;
    logic [31:0] w_off;
    logic        w_in_win;
    logic        w_unused_off;
    logic [31:0] w_rsp_rdata;

    owner_e      r_rsp_owner;
    logic        r_rsp_we;
    logic        r_rsp_oob;
    logic [31:0] r_err_addr;
    logic [31:0] r_instr_rdata;
    logic [31:0] r_data_rdata;

    rr_arb2 u_rr_arb2 (
        .clk  (clk),
        .rstn (rstn),
        .req  ({data_req, instr_req}),
        .adv  (w_any_gnt),
        .gnt  (w_gnt)
    );

    assign instr_gnt  = w_gnt[0];
    assign data_gnt   = w_gnt[1];
    assign w_any_gnt  = |w_gnt;
    assign w_sel_data = w_gnt[1];
    assign w_is_store = w_sel_data & data_we;
    assign w_addr     = w_sel_data ? data_addr : instr_addr;
    assign w_off      = w_addr - MEM_BASE;
    assign w_in_win   = in_window(w_addr, MEM_BASE, MEM_AW);

    // Byte-lane bits and bits above the window are intentionally dropped from the word address.
    assign w_unused_off = ^{w_off[1:0], w_off[31:MEM_AW+2]};

    // Drive the SRAM in the grant cycle; out-of-window accesses never touch it.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = w_off[MEM_AW+1:2];
        mem_wdata = data_wdata;
        if (w_any_gnt && w_in_win) begin
            mem_en = 1'b1;
            if (w_is_store) begin
                mem_we = data_be;
            end
        end
    end

    // Record who owns next cycle's response and what kind of response it is.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_owner <= OWN_NONE;
            r_rsp_we    <= 1'b0;
            r_rsp_oob   <= 1'b0;
            r_err_addr  <= 32'h0;
        end else if (w_any_gnt) begin
            r_rsp_owner <= w_sel_data ? OWN_DATA : OWN_INSTR;
            r_rsp_we    <= w_is_store;
            r_rsp_oob   <= !w_in_win;
            if (!w_in_win) begin
                r_err_addr <= w_addr;
            end
        end else begin
            r_rsp_owner <= OWN_NONE;
            r_rsp_we    <= 1'b0;
            r_rsp_oob   <= 1'b0;
        end
    end

    // Response data: stores return zero, out-of-window reads the error pattern, else the SRAM.
    always_comb begin
        w_rsp_rdata = mem_rdata;
        if (r_rsp_we) begin
            w_rsp_rdata = 32'h0;
        end else if (r_rsp_oob) begin
            w_rsp_rdata = ERR_RDATA;
        end
    end

    // Keep each port's last response so its rdata stays stable while the other port is served.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_instr_rdata <= 32'h0;
            r_data_rdata  <= 32'h0;
        end else begin
            if (r_rsp_owner == OWN_INSTR) begin
                r_instr_rdata <= w_rsp_rdata;
            end
            if (r_rsp_owner == OWN_DATA) begin
                r_data_rdata <= w_rsp_rdata;
            end
        end
    end

    assign instr_rvalid = (r_rsp_owner == OWN_INSTR);
    assign data_rvalid  = (r_rsp_owner == OWN_DATA);
    assign instr_rdata  = instr_rvalid ? w_rsp_rdata : r_instr_rdata;
    assign data_rdata   = data_rvalid ? w_rsp_rdata : r_data_rdata;
    assign bus_err      = (r_rsp_owner != OWN_NONE) && r_rsp_oob;
    assign err_addr     = r_err_addr;

endmodule
